uart_configurable_receiver: RTL and testbench

Synthesisable UART receive engine with run-time configuration of the frame format.
- Frame format: data width 5–8, parity enable/even/odd, 1 or 2 stop bits, oversampling 16 or 13, programmable baud divisor.
- Checks each frame for parity, framing, break and overrun errors.
- Presents the received byte plus error flags through a valid/ready holding register.
- Serves as the RTL DUT counterpart of the UART verification environment; the configuration encodings match the shared UART global package.

---
 rtl/uart_configurable_receiver_pkg.sv | 74 +++++++
 rtl/uart_configurable_receiver_baud_tick_gen.sv | 32 +++
 rtl/uart_configurable_receiver.sv | 211 +++++++++++++++++++++
 tb/tb_uart_configurable_receiver.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_configurable_receiver_pkg.sv
// Shared UART definitions: frame-format encodings, receiver FSM states and
// the per-frame configuration snapshot used by the receive engine.
package uart_configurable_receiver_pkg;

  typedef enum logic [4:0] {
    UART_OS_13 = 5'd13,
    UART_OS_16 = 5'd16
  } UartOverSamplingEnum;

  typedef enum logic [3:0] {
    UART_DW_5 = 4'd5,
    UART_DW_6 = 4'd6,
    UART_DW_7 = 4'd7,
    UART_DW_8 = 4'd8
  } UartDataWidthEnum;

  typedef enum logic [1:0] {
    UART_STOP_1 = 2'd1,
    UART_STOP_2 = 2'd2
  } UartStopBitsEnum;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_IDLE
  } UartRxStateEnum;

  typedef struct packed {
    UartDataWidthEnum    dataBits;
    logic                parityEnable;
    logic                parityOdd;
    UartStopBitsEnum     stopBits;
    UartOverSamplingEnum overSampling;
  } UartRxCfgStruct;

  localparam int unsigned UART_OS16_HALF_TICKS = 8;
  localparam int unsigned UART_OS13_HALF_TICKS = 6;

  localparam UartRxCfgStruct UART_RX_CFG_DEFAULT = '{
    dataBits:     UART_DW_8,
    parityEnable: 1'b0,
    parityOdd:    1'b0,
    stopBits:     UART_STOP_1,
    overSampling: UART_OS_16
  };

  // Out-of-range encodings fall back to the 8-bit / 1-stop / x16 format.
  function automatic UartRxCfgStruct uart_rx_clamp_cfg(
    input logic [3:0] data_bits,
    input logic       parity_enable,
    input logic       parity_odd,
    input logic [1:0] stop_bits,
    input logic [4:0] over_sampling
  );
    UartRxCfgStruct cfg;
    cfg.dataBits     = (data_bits inside {[4'd5:4'd8]}) ? UartDataWidthEnum'(data_bits) : UART_DW_8;
    cfg.parityEnable = parity_enable;
    cfg.parityOdd    = parity_odd;
    cfg.stopBits     = (stop_bits == 2'd2) ? UART_STOP_2 : UART_STOP_1;
    cfg.overSampling = (over_sampling == 5'd13) ? UART_OS_13 : UART_OS_16;
    return cfg;
  endfunction

  function automatic logic [3:0] uart_rx_last_tick(input UartOverSamplingEnum os, input logic half_bit);
    logic [3:0] last;
    if (half_bit) last = (os == UART_OS_13) ? 4'(UART_OS13_HALF_TICKS - 1) : 4'(UART_OS16_HALF_TICKS - 1);
    else          last = (os == UART_OS_13) ? 4'd12 : 4'd15;
    return last;
  endfunction

endpackage

// File: rtl/uart_configurable_receiver_baud_tick_gen.sv
// Oversample tick generator: one-cycle pulse every divisor clocks, with a
// synchronous restart so the tick phase can be aligned to a start edge.
module uart_baud_tick_gen #(
  parameter int DIVISOR_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic                     restart_i,
  input  logic [DIVISOR_WIDTH-1:0] divisor_i,
  output logic                     tick_o
);

  localparam logic [DIVISOR_WIDTH-1:0] ONE = DIVISOR_WIDTH'(1);

  logic [DIVISOR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIVISOR_WIDTH-1:0] last_count;
  logic                     wrap;

  // Divisor 0 behaves as 1; >= keeps the counter sane if the divisor shrinks.
  always_comb begin
    last_count = (divisor_i == '0) ? '0 : divisor_i - ONE;
    wrap       = (cnt_q >= last_count);
    tick_o     = wrap & ~restart_i;
    cnt_d      = (restart_i || wrap) ? '0 : cnt_q + ONE;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_configurable_receiver.sv
// UART receive engine with per-frame configuration snapshot, parity/framing/
// break/overrun detection and a valid/ready holding register.
module uart_configurable_receiver
  import uart_configurable_receiver_pkg::*;
#(
  parameter int MAX_DATA_WIDTH = 8,
  parameter int DIVISOR_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rxSerial,
  input  logic [3:0]                cfgDataBits,
  input  logic                      cfgParityEnable,
  input  logic                      cfgParityOdd,
  input  logic [1:0]                cfgStopBits,
  input  logic [4:0]                cfgOverSampling,
  input  logic [DIVISOR_WIDTH-1:0]  cfgBaudDivisor,
  output logic [MAX_DATA_WIDTH-1:0] rxData,
  output logic                      rxValid,
  input  logic                      rxReady,
  output logic                      parityError,
  output logic                      framingError,
  output logic                      breakError,
  output logic                      overrunError,
  output logic                      busy
);

  // [0] first sync stage, [1] synchronised line, [2] previous synchronised value
  logic [2:0] sync_q;
  logic       line, fall;

  UartRxStateEnum           state_q, state_d;
  UartRxCfgStruct           cfg_q, cfg_d;
  logic [DIVISOR_WIDTH-1:0] div_q, div_d;
  logic [3:0]               tick_cnt_q, tick_cnt_d;
  logic [3:0]               bit_cnt_q, bit_cnt_d;
  logic [MAX_DATA_WIDTH-1:0] shift_q, shift_d;
  logic par_err_q, par_err_d, frm_err_q, frm_err_d, brk_q, brk_d;
  logic zero_q, zero_d, done_q, done_d;
  logic tick, restart, bit_done;

  logic [MAX_DATA_WIDTH-1:0] data_q;
  logic valid_q, perr_q, ferr_q, berr_q, ovr_q, xfer;

  assign line = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 3'b111;
    else        sync_q <= {sync_q[1:0], rxSerial};
  end

  uart_baud_tick_gen #(.DIVISOR_WIDTH(DIVISOR_WIDTH)) u_tick_gen (
    .clk       (clk),
    .rst_ni    (reset),
    .restart_i (restart),
    .divisor_i (div_q),
    .tick_o    (tick)
  );

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    div_d      = div_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    brk_d      = brk_q;
    zero_d     = zero_q;
    done_d     = 1'b0;
    restart    = 1'b0;
    bit_done   = tick && (tick_cnt_q == uart_rx_last_tick(cfg_q.overSampling, 1'b0));
    if (tick && state_q != RX_IDLE && state_q != RX_WAIT_IDLE) tick_cnt_d = tick_cnt_q + 4'd1;

    case (state_q)
      RX_IDLE: begin
        if (fall) begin
          state_d    = RX_START;
          restart    = 1'b1;
          cfg_d      = uart_rx_clamp_cfg(cfgDataBits, cfgParityEnable, cfgParityOdd,
                                         cfgStopBits, cfgOverSampling);
          div_d      = cfgBaudDivisor;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          shift_d    = '0;
          par_err_d  = 1'b0;
          frm_err_d  = 1'b0;
          brk_d      = 1'b0;
          zero_d     = 1'b1;
        end
      end
      RX_START: begin
        if (tick && tick_cnt_q == uart_rx_last_tick(cfg_q.overSampling, 1'b1)) begin
          tick_cnt_d = '0;
          state_d    = line ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_done) begin
          tick_cnt_d = '0;
          shift_d    = shift_q | (MAX_DATA_WIDTH'(line) << bit_cnt_q);
          zero_d     = zero_q & ~line;
          if (bit_cnt_q == 4'(cfg_q.dataBits) - 4'd1) begin
            bit_cnt_d = '0;
            state_d   = cfg_q.parityEnable ? RX_PARITY : RX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      RX_PARITY: begin
        if (bit_done) begin
          tick_cnt_d = '0;
          par_err_d  = ((^shift_q) ^ line) != cfg_q.parityOdd;
          zero_d     = zero_q & ~line;
          state_d    = RX_STOP;
        end
      end
      RX_STOP: begin
        if (bit_done) begin
          tick_cnt_d = '0;
          if (!line) frm_err_d = 1'b1;
          // Break: everything from start through the first stop bit was low.
          if (bit_cnt_q == 4'd0 && !line && zero_q) begin
            brk_d     = 1'b1;
            frm_err_d = 1'b1;
          end
          if (bit_cnt_q == ((cfg_q.stopBits == UART_STOP_2) ? 4'd1 : 4'd0)) begin
            bit_cnt_d = '0;
            done_d    = 1'b1;
            state_d   = brk_d ? RX_WAIT_IDLE : RX_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      RX_WAIT_IDLE: begin
        if (line) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RX_IDLE;
      cfg_q      <= UART_RX_CFG_DEFAULT;
      div_q      <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      brk_q      <= 1'b0;
      zero_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      brk_q      <= brk_d;
      zero_q     <= zero_d;
      done_q     <= done_d;
    end
  end

  assign xfer = valid_q & rxReady;

  // A completing frame is dropped (and flagged) only if the held entry stays.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      berr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (done_q && (!valid_q || xfer)) begin
      data_q  <= shift_q;
      valid_q <= 1'b1;
      perr_q  <= par_err_q;
      ferr_q  <= frm_err_q;
      berr_q  <= brk_q;
      ovr_q   <= 1'b0;
    end else if (done_q) begin
      ovr_q   <= 1'b1;
    end else if (xfer) begin
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      berr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign rxData       = data_q;
  assign rxValid      = valid_q;
  assign parityError  = perr_q;
  assign framingError = ferr_q;
  assign breakError   = berr_q;
  assign overrunError = ovr_q;
  assign busy         = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_configurable_receiver.sv
// Self-checking bench: directed frames from the test plan plus random frame
// formats, each compared against expectations derived from the frame bits.
module tb_uart_configurable_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rxSerial = 1'b1;
  logic [3:0]  cfgDataBits = 4'd8;
  logic        cfgParityEnable = 1'b0;
  logic        cfgParityOdd = 1'b0;
  logic [1:0]  cfgStopBits = 2'd1;
  logic [4:0]  cfgOverSampling = 5'd16;
  logic [15:0] cfgBaudDivisor = 16'd4;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxReady = 1'b1;
  logic        parityError, framingError, breakError, overrunError, busy;

  int vectors_applied = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    logic       p;
    logic       f;
    logic       b;
    int         cyc;
  } entry_t;
  entry_t got_q[$];

  uart_configurable_receiver #(.MAX_DATA_WIDTH(8), .DIVISOR_WIDTH(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .rxSerial        (rxSerial),
    .cfgDataBits     (cfgDataBits),
    .cfgParityEnable (cfgParityEnable),
    .cfgParityOdd    (cfgParityOdd),
    .cfgStopBits     (cfgStopBits),
    .cfgOverSampling (cfgOverSampling),
    .cfgBaudDivisor  (cfgBaudDivisor),
    .rxData          (rxData),
    .rxValid         (rxValid),
    .rxReady         (rxReady),
    .parityError     (parityError),
    .framingError    (framingError),
    .breakError      (breakError),
    .overrunError    (overrunError),
    .busy            (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer side: every accepted entry is recorded with the cycle it was seen.
  always @(negedge clk) begin
    if (reset && rxValid && rxReady)
      got_q.push_back('{rxData, parityError, framingError, breakError, cyc});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors_applied++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int eff_bits(input logic [3:0] db);
    return (db >= 4'd5 && db <= 4'd8) ? int'(db) : 8;
  endfunction
  function automatic int eff_os(input logic [4:0] os);
    return (os == 5'd13) ? 13 : 16;
  endfunction
  function automatic int eff_stop(input logic [1:0] sb);
    return (sb == 2'd2) ? 2 : 1;
  endfunction
  function automatic int eff_div(input logic [15:0] dv);
    return (dv == 16'd0) ? 1 : int'(dv);
  endfunction

  task automatic apply_cfg(input logic [3:0] db, input logic pe, input logic po,
                           input logic [1:0] sb, input logic [4:0] os, input logic [15:0] dv);
    cfgDataBits = db; cfgParityEnable = pe; cfgParityOdd = po;
    cfgStopBits = sb; cfgOverSampling = os; cfgBaudDivisor = dv;
    wait_clks(2);
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input logic par_en,
                            input logic pbit, input int nstop, input logic [1:0] stops, input int bit_clks);
    rxSerial = 1'b0;
    wait_clks(bit_clks);
    for (int i = 0; i < nbits; i++) begin
      rxSerial = data[i];
      wait_clks(bit_clks);
    end
    if (par_en) begin
      rxSerial = pbit;
      wait_clks(bit_clks);
    end
    for (int s = 0; s < nstop; s++) begin
      rxSerial = stops[s];
      wait_clks(bit_clks);
    end
    rxSerial = 1'b1;
  endtask

  // Sends one frame and compares the single delivered entry with what the
  // frame bits imply under the clamped configuration.
  task automatic run_frame(input logic [3:0] db, input logic pe, input logic po, input logic [1:0] sb,
                           input logic [4:0] os, input logic [15:0] dv, input logic [7:0] data,
                           input logic flip, input logic [1:0] stops, output int lat);
    int nb, ns, bit_clks, c0;
    logic [7:0] d;
    logic pbit, exp_p, exp_f, exp_b;
    entry_t e;
    nb = eff_bits(db);
    ns = eff_stop(sb);
    bit_clks = eff_os(os) * eff_div(dv);
    d = data & 8'((1 << nb) - 1);
    pbit = logic'(($countones(d) + int'(po)) % 2) ^ flip;
    exp_p = pe && flip;
    exp_f = (stops[0] == 1'b0) || (ns == 2 && stops[1] == 1'b0);
    exp_b = (d == 8'd0) && (!pe || pbit == 1'b0) && (stops[0] == 1'b0);
    exp_f = exp_f | exp_b;
    apply_cfg(db, pe, po, sb, os, dv);
    got_q.delete();
    c0 = cyc;
    send_frame(d, nb, pe, pbit, ns, stops, bit_clks);
    wait_clks(2 * bit_clks);
    $display("frame db=%0d pe=%0d po=%0d sb=%0d os=%0d div=%0d data=0x%02h pbit=%0d stops=%b entries=%0d",
             db, pe, po, sb, os, dv, d, pbit, stops, got_q.size());
    lat = -1;
    check_value("entry_count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      e = got_q.pop_front();
      lat = e.cyc - c0;
      check_value("rx_data", e.data, d);
      check_value("parity_error", e.p, exp_p);
      check_value("framing_error", e.f, exp_f);
      check_value("break_error", e.b, exp_b);
    end
    got_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_value({tag, "_data"}, rxData, 0);
    check_value({tag, "_valid"}, rxValid, 0);
    check_value({tag, "_perr"}, parityError, 0);
    check_value({tag, "_ferr"}, framingError, 0);
    check_value({tag, "_berr"}, breakError, 0);
    check_value({tag, "_ovr"}, overrunError, 0);
    check_value({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int lat;
    int n;
    logic busy_seen;
    logic [3:0] db;
    logic [4:0] os;
    logic [1:0] stops;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    wait_clks(4);

    // 8N1 x16 divisor 4: stop-bit mid sample at 9.5 bit times (608 clk) after the edge
    run_frame(4'd8, 1'b0, 1'b0, 2'd1, 5'd16, 16'd4, 8'hA5, 1'b0, 2'b11, lat);
    $display("latency %0d clk", lat);
    check_value("latency_window", (lat >= 608 && lat <= 643), 1);

    // Parity and framing cases
    run_frame(4'd7, 1'b1, 1'b0, 2'd1, 5'd16, 16'd2, 8'h35, 1'b1, 2'b11, lat);
    run_frame(4'd5, 1'b1, 1'b1, 2'd2, 5'd16, 16'd2, 8'h15, 1'b0, 2'b01, lat);
    // Illegal encodings clamp to 8 bits, 1 stop, x16; divisor 0 acts as 1
    run_frame(4'd3, 1'b0, 1'b0, 2'd0, 5'd20, 16'd0, 8'hC3, 1'b0, 2'b11, lat);
    run_frame(4'd6, 1'b1, 1'b1, 2'd2, 5'd13, 16'd3, 8'h2A, 1'b0, 2'b11, lat);

    // Break: line low for 12 bit times
    apply_cfg(4'd8, 1'b0, 1'b0, 2'd1, 5'd16, 16'd2);
    got_q.delete();
    rxSerial = 1'b0;
    wait_clks(12 * 32);
    check_value("break_count_low", got_q.size(), 1);
    rxSerial = 1'b1;
    wait_clks(3 * 32);
    $display("break hold released entries=%0d", got_q.size());
    check_value("break_count_high", got_q.size(), 1);
    if (got_q.size() > 0) begin
      entry_t e;
      e = got_q.pop_front();
      check_value("break_data", e.data, 8'h00);
      check_value("break_berr", e.b, 1);
      check_value("break_ferr", e.f, 1);
    end
    check_value("break_busy", busy, 0);
    got_q.delete();

    // Overrun: hold 0x11, lose 0x22, then transfer
    apply_cfg(4'd8, 1'b0, 1'b0, 2'd1, 5'd16, 16'd2);
    rxReady = 1'b0;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1, 2'b11, 32); wait_clks(64);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1, 2'b11, 32); wait_clks(64);
    @(negedge clk);
    $display("overrun held data=0x%02h valid=%0d ovr=%0d", rxData, rxValid, overrunError);
    check_value("ovr_valid", rxValid, 1);
    check_value("ovr_data", rxData, 8'h11);
    check_value("ovr_flag", overrunError, 1);
    wait_clks(1);
    rxReady = 1'b1;
    wait_clks(1);
    rxReady = 1'b0;
    @(negedge clk);
    check_value("xfer_valid", rxValid, 0);
    check_value("xfer_ovr", overrunError, 0);
    wait_clks(1);

    // Completion coinciding with a transfer loads the new frame, overrun cleared
    send_frame(8'h44, 8, 1'b0, 1'b0, 1, 2'b11, 32); wait_clks(64);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1, 2'b11, 32); wait_clks(64);
    @(negedge clk);
    check_value("ovr2_flag", overrunError, 1);
    wait_clks(1);
    n = 0;
    fork
      send_frame(8'h33, 8, 1'b0, 1'b0, 1, 2'b11, 32);
      begin
        while (!busy && n < 2000) begin @(negedge clk); n++; end
        while (busy && n < 4000) begin @(negedge clk); n++; end
        #1 rxReady = 1'b1;
        @(negedge clk);
        $display("coincident load data=0x%02h valid=%0d ovr=%0d", rxData, rxValid, overrunError);
        check_value("coinc_wait", (n < 4000), 1);
        check_value("coinc_data", rxData, 8'h33);
        check_value("coinc_valid", rxValid, 1);
        check_value("coinc_ovr", overrunError, 0);
      end
    join
    rxReady = 1'b1;
    wait_clks(64);
    got_q.delete();

    // Short glitch: 4 oversample ticks low is a false start
    apply_cfg(4'd8, 1'b0, 1'b0, 2'd1, 5'd16, 16'd4);
    busy_seen = 1'b0;
    rxSerial = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    wait_clks(1);
    rxSerial = 1'b1;
    wait_clks(128);
    $display("glitch busy_seen=%0d busy=%0d entries=%0d", busy_seen, busy, got_q.size());
    check_value("glitch_busy_seen", busy_seen, 1);
    check_value("glitch_busy", busy, 0);
    check_value("glitch_entries", got_q.size(), 0);
    check_value("glitch_valid", rxValid, 0);

    // Reset mid-frame while an entry is held, then a clean frame
    apply_cfg(4'd8, 1'b0, 1'b0, 2'd1, 5'd16, 16'd2);
    rxReady = 1'b0;
    send_frame(8'h77, 8, 1'b0, 1'b0, 1, 2'b11, 32); wait_clks(64);
    fork
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 2'b11, 32);
      begin
        wait_clks(32 * 4);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
      end
    join
    wait_clks(2);
    reset = 1'b1;
    rxReady = 1'b1;
    wait_clks(4);
    got_q.delete();
    run_frame(4'd8, 1'b0, 1'b0, 2'd1, 5'd16, 16'd2, 8'h3C, 1'b0, 2'b11, lat);

    // Random formats
    for (int k = 0; k < 24; k++) begin
      db = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(5, 8));
      case ($urandom_range(0, 4))
        0, 1:    os = 5'd16;
        2, 3:    os = 5'd13;
        default: os = 5'($urandom_range(0, 31));
      endcase
      stops = 2'b11;
      if ($urandom_range(0, 5) == 0) stops[0] = 1'b0;
      if ($urandom_range(0, 5) == 0) stops[1] = 1'b0;
      run_frame(db, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                os, 16'($urandom_range(0, 3)), 8'($urandom),
                ($urandom_range(0, 3) == 0), stops, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
